// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and legal latency range for the unified-memory bus arbiter.
package mem_arb_pkg;
    typedef enum logic {ST_IDLE, ST_WAIT} arb_state_t;
    typedef enum logic {OWN_IBUS, OWN_DBUS} arb_owner_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 8;
endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory between ibus and dbus; per-transaction grant, reads hold
// the bus for RD_LAT cycles and return data to the owner, writes complete in the grant cycle.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = 0
) (
    input  logic              s_clk_i,
    input  logic              s_reset_i,
    input  logic              s_ibus_req_i,
    input  logic              s_ibus_write_i,
    input  logic [ADDR_W-1:0] s_ibus_add_i,
    input  logic [DATA_W-1:0] s_ibus_val_i,
    output logic              s_ibus_gnt_o,
    output logic              s_ibus_rvalid_o,
    output logic [DATA_W-1:0] s_ibus_val_o,
    input  logic              s_dbus_req_i,
    input  logic              s_dbus_write_i,
    input  logic [ADDR_W-1:0] s_dbus_add_i,
    input  logic [DATA_W-1:0] s_dbus_val_i,
    output logic              s_dbus_gnt_o,
    output logic              s_dbus_rvalid_o,
    output logic [DATA_W-1:0] s_dbus_val_o,
    output logic [ADDR_W-1:0] s_mem_add_o,
    output logic [DATA_W-1:0] s_mem_val_o,
    output logic              s_mem_write_o,
    input  logic [DATA_W-1:0] s_mem_val_i,
    output logic              s_busy_o
);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_check
        $error("mem_bus_arbiter: RD_LAT=%0d outside %0d..%0d", RD_LAT, RD_LAT_MIN, RD_LAT_MAX);
    end

    arb_state_t        state, state_nxt;
    arb_owner_t        last_owner, hold_owner, win;
    logic [ADDR_W-1:0] hold_add;
    logic [CNT_W-1:0]  cnt;
    logic              win_vld, win_write, done;
    logic [ADDR_W-1:0] win_add;
    logic [DATA_W-1:0] win_val;

    // Nothing is granted or returned while reset is asserted, so a reset cycle never commits a write.
    always_comb begin
        win_vld = 1'b0;
        win     = OWN_IBUS;
        if (state == ST_IDLE && !s_reset_i) begin
            if (s_ibus_req_i && s_dbus_req_i) begin
                win_vld = 1'b1;
                if (ARB_MODE == 1)
                    win = OWN_DBUS;
                else
                    win = (last_owner == OWN_IBUS) ? OWN_DBUS : OWN_IBUS;
            end else if (s_ibus_req_i) begin
                win_vld = 1'b1;
                win     = OWN_IBUS;
            end else if (s_dbus_req_i) begin
                win_vld = 1'b1;
                win     = OWN_DBUS;
            end
        end
        win_write = (win == OWN_DBUS) ? s_dbus_write_i : s_ibus_write_i;
        win_add   = (win == OWN_DBUS) ? s_dbus_add_i   : s_ibus_add_i;
        win_val   = (win == OWN_DBUS) ? s_dbus_val_i   : s_ibus_val_i;
        done      = (state == ST_WAIT) && (cnt == CNT_W'(RD_LAT)) && !s_reset_i;
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_owner <= OWN_DBUS;
            hold_owner <= OWN_IBUS;
            hold_add   <= '0;
        end else begin
            state <= state_nxt;
            if (win_vld) begin
                last_owner <= win;
                if (!win_write) begin
                    hold_owner <= win;
                    hold_add   <= win_add;
                    cnt        <= CNT_W'(1);
                end
            end else if (state == ST_WAIT) begin
                cnt <= done ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (win_vld && !win_write) state_nxt = ST_WAIT;
            ST_WAIT: if (done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ibus_gnt_o    = 1'b0;
        s_dbus_gnt_o    = 1'b0;
        s_ibus_rvalid_o = 1'b0;
        s_dbus_rvalid_o = 1'b0;
        s_ibus_val_o    = '0;
        s_dbus_val_o    = '0;
        s_mem_add_o     = '0;
        s_mem_val_o     = '0;
        s_mem_write_o   = 1'b0;
        s_busy_o        = 1'b0;
        if (win_vld) begin
            s_ibus_gnt_o  = (win == OWN_IBUS);
            s_dbus_gnt_o  = (win == OWN_DBUS);
            s_mem_add_o   = win_add;
            s_mem_val_o   = win_val;
            s_mem_write_o = win_write;
        end
        if (state == ST_WAIT && !s_reset_i) begin
            s_busy_o    = 1'b1;
            s_mem_add_o = hold_add;
            if (done) begin
                if (hold_owner == OWN_IBUS) begin
                    s_ibus_rvalid_o = 1'b1;
                    s_ibus_val_o    = s_mem_val_i;
                end else begin
                    s_dbus_rvalid_o = 1'b1;
                    s_dbus_val_o    = s_mem_val_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Two arbiters side by side: dut0 round-robin with RD_LAT=1, dut1 fixed-priority with RD_LAT=3.
module tb_mem_bus_arbiter;
    localparam int K_IGNT = 0;
    localparam int K_DGNT = 1;
    localparam int K_IRV  = 2;
    localparam int K_DRV  = 3;

    typedef struct {
        int          dut;
        int          cyc;
        int          kind;
        logic        w;
        logic [31:0] a;
        logic [31:0] dat;
    } ev_t;

    typedef struct {
        int          dut;
        int          port;
        logic        w;
        logic [31:0] a;
        logic [31:0] dat;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    txn_t tx_q[$];

    logic        req    [2][2];
    logic        wr     [2][2];
    logic [31:0] add    [2][2];
    logic [31:0] wdat   [2][2];
    logic        gnt    [2][2];
    logic        rvalid [2][2];
    logic [31:0] rdat   [2][2];
    logic [31:0] madd [2];
    logic [31:0] mval [2];
    logic        mwr  [2];
    logic        busy [2];

    function automatic logic [31:0] init_word(int i);
        case (i)
            0:       return 32'h1111_1111;
            2:       return 32'h3333_3333;
            4:       return 32'hDEAD_BEEF;
            64:      return 32'h2222_2222;
            65:      return 32'h4444_4444;
            default: return 32'hC0DE_0000 | i;
        endcase
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        logic [31:0] mem [1024];
        logic [31:0] q;

        always @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            end else if (mwr[d]) begin
                mem[madd[d][11:2]] <= mval[d];
            end
            q <= mem[madd[d][11:2]];
        end

        mem_bus_arbiter #(
            .ADDR_W  (32),
            .DATA_W  (32),
            .RD_LAT  ((d == 0) ? 1 : 3),
            .ARB_MODE(d)
        ) u_dut (
            .s_clk_i        (clk),
            .s_reset_i      (rst),
            .s_ibus_req_i   (req[d][0]),
            .s_ibus_write_i (wr[d][0]),
            .s_ibus_add_i   (add[d][0]),
            .s_ibus_val_i   (wdat[d][0]),
            .s_ibus_gnt_o   (gnt[d][0]),
            .s_ibus_rvalid_o(rvalid[d][0]),
            .s_ibus_val_o   (rdat[d][0]),
            .s_dbus_req_i   (req[d][1]),
            .s_dbus_write_i (wr[d][1]),
            .s_dbus_add_i   (add[d][1]),
            .s_dbus_val_i   (wdat[d][1]),
            .s_dbus_gnt_o   (gnt[d][1]),
            .s_dbus_rvalid_o(rvalid[d][1]),
            .s_dbus_val_o   (rdat[d][1]),
            .s_mem_add_o    (madd[d]),
            .s_mem_val_o    (mval[d]),
            .s_mem_write_o  (mwr[d]),
            .s_mem_val_i    (q),
            .s_busy_o       (busy[d])
        );
    end

    task automatic issue_both(int p, logic w, logic [31:0] a, logic [31:0] dat);
        for (int d = 0; d < 2; d++) tx_q.push_back('{dut: d, port: p, w: w, a: a, dat: dat});
    endtask

    task automatic expect_ev(int d, int c, int k, logic w, logic [31:0] a, logic [31:0] dat);
        exp_q.push_back('{dut: d, cyc: c, kind: k, w: w, a: a, dat: dat});
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req_v);
        end
    endtask

    task automatic check_event(ev_t o);
        int   idx[$];
        ev_t  e;
        checks++;
        idx = exp_q.find_first_index(x) with (x.dut == o.dut);
        if (idx.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event dut%0d: got kind=%0d cyc=%0d w=%0b a=%h d=%h, expected none",
                     o.dut, o.kind, o.cyc, o.w, o.a, o.dat);
        end else begin
            e = exp_q[idx[0]];
            exp_q.delete(idx[0]);
            if (e.cyc != o.cyc || e.kind != o.kind || e.w !== o.w || e.a !== o.a || e.dat !== o.dat) begin
                errors++;
                $display("FAIL event dut%0d: got kind=%0d cyc=%0d w=%0b a=%h d=%h, expected kind=%0d cyc=%0d w=%0b a=%h d=%h",
                         o.dut, o.kind, o.cyc, o.w, o.a, o.dat, e.kind, e.cyc, e.w, e.a, e.dat);
            end
        end
    endtask

    // Master model: holds each request until it sees its grant, then presents the next one.
    initial begin : bfm
        txn_t cur  [2][2];
        bit   act  [2][2];
        bit   seen [2][2];
        int   idx[$];
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                act[d][p]  = 1'b0;
                req[d][p]  = 1'b0;
                wr[d][p]   = 1'b0;
                add[d][p]  = '0;
                wdat[d][p] = '0;
            end
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) seen[d][p] = gnt[d][p];
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    if (act[d][p] && seen[d][p]) act[d][p] = 1'b0;
                    if (!act[d][p]) begin
                        idx = tx_q.find_first_index(x) with (x.dut == d && x.port == p);
                        if (idx.size() > 0) begin
                            cur[d][p] = tx_q[idx[0]];
                            tx_q.delete(idx[0]);
                            act[d][p] = 1'b1;
                        end
                    end
                    req[d][p]  = act[d][p];
                    wr[d][p]   = act[d][p] ? cur[d][p].w   : 1'b0;
                    add[d][p]  = act[d][p] ? cur[d][p].a   : 32'h0;
                    wdat[d][p] = act[d][p] ? cur[d][p].dat : 32'h0;
                end
            end
        end
    end

    initial begin : monitor
        ev_t  o;
        logic hit;
        logic anyg;
        bit   ok;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 4; k++) begin
                    hit = (k < 2) ? gnt[d][k] : rvalid[d][k-2];
                    if (hit) begin
                        o.dut  = d;
                        o.cyc  = cyc;
                        o.kind = k;
                        o.w    = (k < 2) ? mwr[d]  : 1'b0;
                        o.a    = (k < 2) ? madd[d] : 32'h0;
                        o.dat  = (k < 2) ? mval[d] : rdat[d][k-2];
                        check_event(o);
                    end
                end
                anyg = gnt[d][0] | gnt[d][1];
                ok   = 1'b1;
                if (!anyg && (mwr[d] !== 1'b0 || mval[d] !== 32'h0)) ok = 1'b0;
                if (!anyg && !busy[d] && madd[d] !== 32'h0) ok = 1'b0;
                if (!rvalid[d][0] && rdat[d][0] !== 32'h0) ok = 1'b0;
                if (!rvalid[d][1] && rdat[d][1] !== 32'h0) ok = 1'b0;
                if (gnt[d][0] && gnt[d][1]) ok = 1'b0;
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL quiet_outputs dut%0d cycle %0d: got gnt=%b%b wr=%b add=%h val=%h rdat=%h/%h busy=%b, expected zeros outside grant/rvalid",
                             d, cyc, gnt[d][0], gnt[d][1], mwr[d], madd[d], mval[d], rdat[d][0], rdat[d][1], busy[d]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of stimulus, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int b;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("reset_busy_dut0", 32'(busy[0]), 32'h0);
            chk("reset_busy_dut1", 32'(busy[1]), 32'h0);
        end

        // Both masters request together, two reads each.
        @(negedge clk); #1; b = cyc + 1;
        issue_both(0, 1'b0, 32'h0,   32'h0);
        issue_both(0, 1'b0, 32'h8,   32'h0);
        issue_both(1, 1'b0, 32'h100, 32'h0);
        issue_both(1, 1'b0, 32'h104, 32'h0);
        expect_ev(0, b + 0, K_IGNT, 1'b0, 32'h0,   32'h0);
        expect_ev(0, b + 1, K_IRV,  1'b0, 32'h0,   32'h1111_1111);
        expect_ev(0, b + 2, K_DGNT, 1'b0, 32'h100, 32'h0);
        expect_ev(0, b + 3, K_DRV,  1'b0, 32'h0,   32'h2222_2222);
        expect_ev(0, b + 4, K_IGNT, 1'b0, 32'h8,   32'h0);
        expect_ev(0, b + 5, K_IRV,  1'b0, 32'h0,   32'h3333_3333);
        expect_ev(0, b + 6, K_DGNT, 1'b0, 32'h104, 32'h0);
        expect_ev(0, b + 7, K_DRV,  1'b0, 32'h0,   32'h4444_4444);
        expect_ev(1, b + 0,  K_DGNT, 1'b0, 32'h100, 32'h0);
        expect_ev(1, b + 3,  K_DRV,  1'b0, 32'h0,   32'h2222_2222);
        expect_ev(1, b + 4,  K_DGNT, 1'b0, 32'h104, 32'h0);
        expect_ev(1, b + 7,  K_DRV,  1'b0, 32'h0,   32'h4444_4444);
        expect_ev(1, b + 8,  K_IGNT, 1'b0, 32'h0,   32'h0);
        expect_ev(1, b + 11, K_IRV,  1'b0, 32'h0,   32'h1111_1111);
        expect_ev(1, b + 12, K_IGNT, 1'b0, 32'h8,   32'h0);
        expect_ev(1, b + 15, K_IRV,  1'b0, 32'h0,   32'h3333_3333);
        repeat (20) @(negedge clk);

        // Single ibus read; busy tracks the read latency.
        @(negedge clk); #1; b = cyc + 1;
        issue_both(0, 1'b0, 32'h10, 32'h0);
        expect_ev(0, b,     K_IGNT, 1'b0, 32'h10, 32'h0);
        expect_ev(0, b + 1, K_IRV,  1'b0, 32'h0,  32'hDEAD_BEEF);
        expect_ev(1, b,     K_IGNT, 1'b0, 32'h10, 32'h0);
        expect_ev(1, b + 3, K_IRV,  1'b0, 32'h0,  32'hDEAD_BEEF);
        @(negedge clk);
        @(negedge clk);
        chk("read_busy_dut0", 32'(busy[0]), 32'h1);
        chk("read_busy_dut1", 32'(busy[1]), 32'h1);
        @(negedge clk);
        chk("read_done_busy_dut0", 32'(busy[0]), 32'h0);
        chk("read_wait_busy_dut1", 32'(busy[1]), 32'h1);
        repeat (8) @(negedge clk);

        // dbus write then ibus read of the same word.
        @(negedge clk); #1; b = cyc + 1;
        issue_both(1, 1'b1, 32'h40, 32'h1234_5678);
        issue_both(0, 1'b0, 32'h40, 32'h0);
        expect_ev(0, b,     K_DGNT, 1'b1, 32'h40, 32'h1234_5678);
        expect_ev(0, b + 1, K_IGNT, 1'b0, 32'h40, 32'h0);
        expect_ev(0, b + 2, K_IRV,  1'b0, 32'h0,  32'h1234_5678);
        expect_ev(1, b,     K_DGNT, 1'b1, 32'h40, 32'h1234_5678);
        expect_ev(1, b + 1, K_IGNT, 1'b0, 32'h40, 32'h0);
        expect_ev(1, b + 4, K_IRV,  1'b0, 32'h0,  32'h1234_5678);
        repeat (8) @(negedge clk);

        // Reset two cycles into a dbus read abandons it on the RD_LAT=3 arbiter.
        @(negedge clk); #1; b = cyc + 1;
        issue_both(1, 1'b0, 32'h100, 32'h0);
        expect_ev(0, b,     K_DGNT, 1'b0, 32'h100, 32'h0);
        expect_ev(0, b + 1, K_DRV,  1'b0, 32'h0,   32'h2222_2222);
        expect_ev(1, b,     K_DGNT, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("lat3_busy_before_reset", 32'(busy[1]), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        issue_both(0, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        expect_ev(0, b + 3, K_IGNT, 1'b0, 32'h10, 32'h0);
        expect_ev(0, b + 4, K_IRV,  1'b0, 32'h0,  32'hDEAD_BEEF);
        expect_ev(1, b + 3, K_IGNT, 1'b0, 32'h10, 32'h0);
        expect_ev(1, b + 6, K_IRV,  1'b0, 32'h0,  32'hDEAD_BEEF);
        @(negedge clk);
        chk("post_reset_busy_dut1", 32'(busy[1]), 32'h0);
        repeat (10) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: got %0d outstanding events, expected 0", exp_q.size());
            foreach (exp_q[i])
                $display("  outstanding dut%0d kind=%0d cyc=%0d a=%h d=%h",
                         exp_q[i].dut, exp_q[i].kind, exp_q[i].cyc, exp_q[i].a, exp_q[i].dat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one single-ported memory between the CPU instruction bus and data bus, so a unified memory can replace the separate program and data memories. Sits between cpu_top (ibus/dbus masters) and one memory instance. Arbitrates per transaction, sequences the fixed memory read latency, and routes read data back to the owning master with a valid pulse.

Parameters:
ADDR_W, 32, address width of all buses
DATA_W, 32, data width of all buses
RD_LAT, 1, cycles from address issue to valid s_mem_val_i; legal 1..8; elaboration error otherwise
ARB_MODE, 0, 0 = round-robin between ibus/dbus, 1 = fixed priority with dbus winning ties

Ports:
s_clk_i  in  1  clock, rising edge
s_reset_i  in  1  synchronous, active-high reset
s_ibus_req_i  in  1  instruction master requests a transaction
s_ibus_write_i  in  1  1 = write, 0 = read
s_ibus_add_i  in  ADDR_W  ibus address
s_ibus_val_i  in  DATA_W  ibus write data
s_ibus_gnt_o  out  1  request accepted this cycle
s_ibus_rvalid_o  out  1  read data valid on s_ibus_val_o
s_ibus_val_o  out  DATA_W  ibus read data
s_dbus_req_i, s_dbus_write_i, s_dbus_add_i, s_dbus_val_i, s_dbus_gnt_o, s_dbus_rvalid_o, s_dbus_val_o: same directions, widths and meaning as the ibus ports, for the data master
s_mem_add_o  out  ADDR_W  memory address
s_mem_val_o  out  DATA_W  memory write data
s_mem_write_o  out  1  memory write strobe
s_mem_val_i  in  DATA_W  memory read data
s_busy_o  out  1  read outstanding (state WAIT)

Behaviour:
- FSM states: IDLE, WAIT. Register last_owner (IBUS/DBUS). Latency counter cnt, width $clog2(RD_LAT+1).
- Reset (s_reset_i high at a rising edge): state=IDLE, cnt=0, last_owner=DBUS, hold registers=0. Any outstanding read is abandoned with no rvalid.
- Reset output values, and IDLE with no request: all gnt/rvalid=0, s_mem_write_o=0, s_mem_add_o=0, s_mem_val_o=0, s_busy_o=0. Read-data outputs are 0 whenever their rvalid is 0.
- IDLE with request(s): the winner is chosen combinationally.
  - Single requester: that requester wins.
  - Tie, ARB_MODE=0: the port that is not last_owner wins, so the first tie after reset goes to ibus.
  - Tie, ARB_MODE=1: dbus wins.
- Grant cycle (IDLE with a winner):
  - Winner's gnt_o=1 in the same cycle. Winner's add/val/write drive the s_mem_* outputs combinationally.
  - last_owner <= winner.
  - Write: s_mem_write_o=1 for exactly this cycle. Memory captures on the edge. No rvalid. Stay in IDLE; a new grant is possible the next cycle.
  - Read: s_mem_write_o=0. Latch owner and address into hold registers. cnt <= 1. Go to WAIT.
- WAIT:
  - s_mem_add_o = held address, s_mem_write_o=0, s_mem_val_o=0, s_busy_o=1.
  - No gnt asserted.
  - cnt increments each cycle.
- Read completion: on the cycle where cnt==RD_LAT in WAIT (or the cycle after grant when RD_LAT=1):
  - Owner's rvalid_o=1 for one cycle.
  - Owner's val_o = s_mem_val_i.
  - Next state IDLE.
- Read timing: read data arrives RD_LAT cycles after gnt. Peak read throughput is one read per RD_LAT+1 cycles. Back-to-back writes run one per cycle.
- Requester contract: req/add/write/val must be held stable until gnt. Deasserting req before gnt is legal and leaves no side effects. A request present during WAIT waits and is arbitrated in the following IDLE cycle.
- Round-robin fairness: with both masters requesting continuously, grants strictly alternate.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic {ST_IDLE, ST_WAIT} arb_state_t
  - typedef enum logic {OWN_IBUS, OWN_DBUS} arb_owner_t
  - localparam limits RD_LAT_MIN=1, RD_LAT_MAX=8
- No sub-module. Winner selection and the counter stay inline; the block is about 150-250 lines.

Test Plan:
1. Reset held 2 cycles, then released with no requests -> all outputs 0, s_busy_o=0 for 5 cycles.
2. RD_LAT=1. ibus read of 0x10; memory model returns 0xDEADBEEF -> s_ibus_gnt_o=1 and s_mem_add_o=0x10 in cycle 0; s_ibus_rvalid_o=1 with 0xDEADBEEF in cycle 1; dbus outputs stay 0.
3. ARB_MODE=0. ibus reads 0x0 and dbus reads 0x100, both from cycle 0 and held -> ibus gnt in cycle 0, ibus rvalid in cycle 1; dbus gnt in cycle 2, dbus rvalid in cycle 3. Requests held continuously keep alternating I, D, I, D.
4. ARB_MODE=1, same stimulus as scenario 3 -> dbus granted first in cycle 0, ibus in cycle 2.
5. dbus write of 0x12345678 to 0x40, then ibus read of 0x40 -> s_mem_write_o pulses for 1 cycle; no dbus rvalid; ibus gnt the next cycle; ibus rvalid returns 0x12345678.
6. RD_LAT=3. dbus read granted; s_reset_i asserted 2 cycles after gnt -> no rvalid ever; state IDLE; a new ibus request after reset is granted immediately.
